// File: rtl/fetch_lmsm_stage_if.sv
// Fetch-to-decode bundle: redirect/stall control, instruction-memory port and the IF/ID register outputs.
interface fetch_lmsm_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        modify_ir;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        valid_out;
  logic [2:0]  lm_index;
  logic        busy;

  modport slave (
    input  stall, redirect, redirect_pc, imem_data, modify_ir,
    output imem_addr, ir_out, pc_out, pc_plus1, valid_out, lm_index, busy
  );

  modport master (
    output stall, redirect, redirect_pc, imem_data, modify_ir,
    input  imem_addr, ir_out, pc_out, pc_plus1, valid_out, lm_index, busy
  );
endinterface

// File: rtl/fetch_lmsm_stage.sv
// Fetch stage + IF/ID register; re-issues LM/SM once per mask bit while freezing the fetch PC.
module fetch_lmsm_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'hF000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_lmsm_stage_if.slave  bus
);

  typedef enum logic {S_FETCH, S_MULTI} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_pc_out;
  logic [15:0] r_pc_plus1;
  logic        r_valid;
  logic [2:0]  r_lm_index;
  logic        r_busy;

  logic [7:0]  w_mask;
  logic [7:0]  w_mask_rest;
  logic        w_is_lmsm;
  logic        w_lm_more;

  // mask & (mask-1) drops the lowest set bit; non-zero means at least two bits remain
  assign w_mask      = r_ir[7:0];
  assign w_mask_rest = w_mask & (w_mask - 8'd1);
  assign w_is_lmsm   = (r_ir[15:13] == 3'b011);
  assign w_lm_more   = r_valid & w_is_lmsm & bus.modify_ir & (w_mask_rest != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_ir       <= NOP_IR;
      r_pc_out   <= 16'h0000;
      r_pc_plus1 <= 16'h0000;
      r_valid    <= 1'b0;
      r_lm_index <= 3'd0;
      r_state    <= S_FETCH;
      r_busy     <= 1'b0;
    end else if (bus.redirect) begin
      r_pc       <= bus.redirect_pc;
      r_ir       <= NOP_IR;
      r_valid    <= 1'b0;
      r_lm_index <= 3'd0;
      r_state    <= S_FETCH;
      r_busy     <= 1'b0;
    end else if (bus.stall) begin
      r_state <= r_state;
    end else if (w_lm_more) begin
      r_ir       <= {r_ir[15:8], w_mask_rest};
      r_lm_index <= r_lm_index + 3'd1;
      r_state    <= S_MULTI;
      r_busy     <= 1'b1;
    end else begin
      r_ir       <= bus.imem_data;
      r_pc_out   <= r_pc;
      r_pc_plus1 <= r_pc + 16'd1;
      r_valid    <= 1'b1;
      r_pc       <= r_pc + 16'd1;
      r_lm_index <= 3'd0;
      r_state    <= S_FETCH;
      r_busy     <= 1'b0;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.ir_out    = r_ir;
  assign bus.pc_out    = r_pc_out;
  assign bus.pc_plus1  = r_pc_plus1;
  assign bus.valid_out = r_valid;
  assign bus.lm_index  = r_lm_index;
  assign bus.busy      = r_busy;

endmodule
